// File: rtl/ex_alu_seq_if.sv
// Handshake bundle between ID/EX, the execute-stage ALU and EX/MEM.
// The request side carries the operation. The response side carries the
// registered result and its destination tags.
interface ex_alu_seq_if #(
  parameter int XLEN = 32
);
  // ID/EX -> ALU
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            reg_wr_in;

  // ALU -> EX/MEM
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [4:0]      rd_out;
  logic            reg_wr_out;

  // Pipeline side: presents operations and consumes results.
  modport master (
    output in_valid, alu_ctrl, op_a, op_b, rd_in, reg_wr_in, out_ready,
    input  in_ready, out_valid, result, zero, rd_out, reg_wr_out
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, rd_in, reg_wr_in, out_ready,
    output in_ready, out_valid, result, zero, rd_out, reg_wr_out
  );
endinterface

// File: rtl/ex_alu_seq.sv
// Execute-stage ALU with a registered output slot.
// Logical, add/sub and pass ops finish on the accept edge. Shifts use an
// iterative 1-bit-per-cycle shifter, so the block stalls ID/EX while a
// shift is running.
module ex_alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  ex_alu_seq_if.slave  bus
);

  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_ADD    = 5'd1,
    OP_SUB    = 5'd2,
    OP_AND    = 5'd3,
    OP_OR     = 5'd4,
    OP_XOR    = 5'd5,
    OP_LSHIFT = 5'd6,
    OP_RSHIFT = 5'd7,
    OP_PASS_B = 5'd8
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  // Control / shifter state
  state_e              r_state;
  logic [XLEN-1:0]     r_acc;
  logic [SHAMT_W-1:0]  r_count;
  logic                r_dir_right;
  logic [4:0]          r_rd;
  logic                r_reg_wr;

  // Output slot
  logic                r_out_valid;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic [4:0]          r_rd_out;
  logic                r_reg_wr_out;

  // Combinational helpers
  logic                w_slot_free;
  logic                w_xfer;
  logic                w_in_ready;
  logic                w_accept;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [XLEN-1:0]     w_alu_val;
  logic [XLEN-1:0]     w_shift_val;
  logic                w_wr_en;
  logic [XLEN-1:0]     w_wr_val;
  logic [4:0]          w_wr_rd;
  logic                w_wr_reg_wr;
  logic                w_start_shift;

  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_xfer      = r_out_valid && bus.out_ready;
  assign w_in_ready  = (r_state == S_IDLE) && w_slot_free && !flush && !rst;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_shamt     = bus.op_b[SHAMT_W-1:0];
  assign w_shift_val = r_dir_right ? (r_acc >> 1) : (r_acc << 1);

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.result     = r_result;
  assign bus.zero       = r_zero;
  assign bus.rd_out     = r_rd_out;
  assign bus.reg_wr_out = r_reg_wr_out;

  // Single-cycle datapath. Add/sub wrap, and carry/overflow are discarded.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    w_alu_val = bus.op_a;
    case (bus.alu_ctrl)
      OP_ADD:    w_alu_val = bus.op_a + bus.op_b;
      OP_SUB:    w_alu_val = bus.op_a - bus.op_b;
      OP_AND:    w_alu_val = bus.op_a & bus.op_b;
      OP_OR:     w_alu_val = bus.op_a | bus.op_b;
      OP_XOR:    w_alu_val = bus.op_a ^ bus.op_b;
      OP_PASS_B: w_alu_val = bus.op_b;
      default:   w_alu_val = bus.op_a;
    endcase
  end

  // Choose what, if anything, is written into the output slot this cycle.
  always_comb begin
    w_wr_en       = 1'b0;
    w_wr_val      = w_alu_val;
    w_wr_rd       = bus.rd_in;
    w_wr_reg_wr   = bus.reg_wr_in;
    w_start_shift = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        case (bus.alu_ctrl)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASS_B: w_wr_en = 1'b1;
          OP_LSHIFT, OP_RSHIFT: begin
            if (w_shamt == '0) begin
              w_wr_en  = 1'b1;
              w_wr_val = bus.op_a;
            end else begin
              w_start_shift = 1'b1;
            end
          end
          default: w_wr_en = 1'b0;  // NOP and unused codes are bubbles
        endcase
      end
    end else if (r_count == SHAMT_W'(1) && w_slot_free) begin
      // The final shift goes straight into the result register.
      w_wr_en     = 1'b1;
      w_wr_val    = w_shift_val;
      w_wr_rd     = r_rd;
      w_wr_reg_wr = r_reg_wr;
    end
  end

  // Output slot and shifter FSM. Reset wins over flush, and flush wins over
  // any accept or completion.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every branch
    // reads the pre-edge values and the block does not depend on statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_count      <= '0;
      r_dir_right  <= 1'b0;
      r_rd         <= '0;
      r_reg_wr     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b1;
      r_rd_out     <= '0;
      r_reg_wr_out <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_state     <= S_IDLE;
      r_count     <= '0;
    end else begin
      if (w_wr_en) begin
        r_out_valid  <= 1'b1;
        r_result     <= w_wr_val;
        r_zero       <= (w_wr_val == '0);
        r_rd_out     <= w_wr_rd;
        r_reg_wr_out <= w_wr_reg_wr;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start_shift) begin
            r_acc       <= bus.op_a;
            r_count     <= w_shamt;
            r_dir_right <= (bus.alu_ctrl == OP_RSHIFT);
            r_rd        <= bus.rd_in;
            r_reg_wr    <= bus.reg_wr_in;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_count > SHAMT_W'(1)) begin
            r_acc   <= w_shift_val;
            r_count <= r_count - SHAMT_W'(1);
          end else if (w_slot_free) begin
            r_acc   <= w_shift_val;
            r_count <= '0;
            r_state <= S_IDLE;
          end
          // Otherwise the last step waits with acc/count unchanged until the slot drains.
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
// Directed self-checking bench for ex_alu_seq. It covers reset, single-cycle
// ops, shift latency, backpressure, throughput, bubbles, flush and reset
// applied in the middle of a shift.
module tb_ex_alu_seq;
  localparam int XLEN = 32;

  localparam logic [4:0] C_NOP    = 5'd0;
  localparam logic [4:0] C_ADD    = 5'd1;
  localparam logic [4:0] C_SUB    = 5'd2;
  localparam logic [4:0] C_AND    = 5'd3;
  localparam logic [4:0] C_OR     = 5'd4;
  localparam logic [4:0] C_XOR    = 5'd5;
  localparam logic [4:0] C_LSHIFT = 5'd6;
  localparam logic [4:0] C_RSHIFT = 5'd7;
  localparam logic [4:0] C_PASS_B = 5'd8;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  ex_alu_seq_if #(.XLEN(XLEN)) bus ();

  ex_alu_seq #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wr);
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = ctrl;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.rd_in     = rd;
    bus.reg_wr_in = wr;
  endtask

  // Present one op, expect it to be accepted on the next edge, then drop in_valid.
  task automatic send(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic wr);
    drive(ctrl, a, b, rd, wr);
    #1;
    check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid rises (bounded).
  task automatic wait_done(output int lat, output int low);
    lat = 0;
    low = 0;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) low++;
      tick();
      lat++;
    end
  endtask

  task automatic run_shift(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int exp_lat);
    int lat, low;
    send(tag, ctrl, a, b, rd, 1'b1);
    wait_done(lat, low);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_stall"}, low, exp_lat);
    check({tag, "_vld"},   {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_res"},   bus.result, exp_res);
    check({tag, "_zero"},  {31'd0, bus.zero}, {31'd0, exp_res == 32'd0});
    check({tag, "_rd"},    {27'd0, bus.rd_out}, {27'd0, rd});
  endtask

  // Single-cycle op vectors with hand-computed results.
  logic [4:0]  v_ctrl [6] = '{C_ADD, C_SUB, C_XOR, C_PASS_B, C_AND, C_OR};
  logic [31:0] v_a    [6] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'h0000_0000,
                              32'hF0F0_F0F0, 32'hF0F0_F0F0};
  logic [31:0] v_b    [6] = '{32'd1, 32'd7, 32'hFF00_FF00, 32'h1234_5678,
                              32'hFF00_FF00, 32'hFF00_FF00};
  logic [31:0] v_exp  [6] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0FF0_0FF0, 32'h1234_5678,
                              32'hF000_F000, 32'hFFF0_FFF0};

  // Throughput vectors
  logic [31:0] t_a   [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [31:0] t_b   [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
  logic [31:0] t_exp [4] = '{32'd11, 32'd22, 32'd33, 32'd44};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, low, seen;

    // Reset asserted for two cycles with an op pending.
    rst           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    drive(C_ADD, 32'd1, 32'd1, 5'd3, 1'b1);
    tick();
    check("rst_in_ready0", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("rst_in_ready1", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result, 32'd0);
    check("rst_zero",      {31'd0, bus.zero}, 32'd1);
    check("rst_rd_out",    {27'd0, bus.rd_out}, 32'd0);
    check("rst_reg_wr",    {31'd0, bus.reg_wr_out}, 32'd0);
    #1;
    check("rst_release_rdy", {31'd0, bus.in_ready}, 32'd1);

    // Single-cycle ops: result is valid straight after the accept edge.
    for (int i = 0; i < 6; i++) begin
      send($sformatf("op%0d", i), v_ctrl[i], v_a[i], v_b[i], 5'(i + 1), 1'(i % 2));
      check($sformatf("op%0d_vld", i),  {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("op%0d_res", i),  bus.result, v_exp[i]);
      check($sformatf("op%0d_zero", i), {31'd0, bus.zero}, {31'd0, v_exp[i] == 32'd0});
      check($sformatf("op%0d_rd", i),   {27'd0, bus.rd_out}, 32'(i + 1));
      check($sformatf("op%0d_wr", i),   {31'd0, bus.reg_wr_out}, 32'(i % 2));
    end

    // Shifts
    run_shift("lsl31",  C_LSHIFT, 32'h0000_0001, 32'd31,   5'd12, 32'h8000_0000, 31);
    run_shift("lsr4",   C_RSHIFT, 32'h8000_0000, 32'd4,    5'd13, 32'h0800_0000, 4);
    run_shift("lsl0",   C_LSHIFT, 32'hDEAD_BEEF, 32'h20,   5'd14, 32'hDEAD_BEEF, 0);
    run_shift("lsr1",   C_RSHIFT, 32'h0000_0003, 32'd1,    5'd15, 32'h0000_0001, 1);
    run_shift("lslout", C_LSHIFT, 32'h8000_0000, 32'd1,    5'd16, 32'h0000_0000, 1);

    // Backpressure on a single-cycle result.
    send("bp", C_ADD, 32'd10, 32'd20, 5'd7, 1'b1);
    bus.out_ready = 1'b0;
    drive(C_ADD, 32'd1, 32'd1, 5'd8, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_rdy%0d", k), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("bp_vld%0d", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp_res%0d", k), bus.result, 32'd30);
      check($sformatf("bp_rd%0d", k),  {27'd0, bus.rd_out}, 32'd7);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_res", bus.result, 32'd2);
    check("bp_next_rd",  {27'd0, bus.rd_out}, 32'd8);

    // A shift that finishes while the consumer is stalled keeps its result.
    send("bpsh", C_LSHIFT, 32'd3, 32'd2, 5'd9, 1'b1);
    bus.out_ready = 1'b0;
    wait_done(lat, low);
    check("bpsh_lat", lat, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bpsh_res%0d", k), bus.result, 32'd12);
      check($sformatf("bpsh_vld%0d", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bpsh_rdy%0d", k), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bpsh_drained", {31'd0, bus.out_valid}, 32'd0);

    // Four back-to-back ADDs, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(C_ADD, t_a[i], t_b[i], 5'(20 + i), 1'b1);
      #1;
      check($sformatf("thr_rdy%0d", i), {31'd0, bus.in_ready}, 32'd1);
      tick();
      check($sformatf("thr_vld%0d", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("thr_res%0d", i), bus.result, t_exp[i]);
      check($sformatf("thr_rd%0d", i),  {27'd0, bus.rd_out}, 32'(20 + i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("thr_end_vld", {31'd0, bus.out_valid}, 32'd0);

    // Bubbles: NOP and an unused code write nothing.
    send("pre_nop", C_ADD, 32'd7, 32'd8, 5'd11, 1'b1);
    check("pre_nop_res", bus.result, 32'd15);
    send("nop", C_NOP, 32'd1, 32'd2, 5'd1, 1'b1);
    check("nop_vld", {31'd0, bus.out_valid}, 32'd0);
    send("code20", 5'd20, 32'd1, 32'd2, 5'd1, 1'b1);
    check("code20_vld", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("code20_vld2", {31'd0, bus.out_valid}, 32'd0);

    // Flush in the middle of a shift, with 10 shift steps still to go.
    send("fl_sh", C_LSHIFT, 32'd1, 32'd20, 5'd5, 1'b1);
    repeat (10) tick();
    check("fl_sh_busy", {31'd0, bus.in_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_sh_vld", {31'd0, bus.out_valid}, 32'd0);
    #1;
    check("fl_sh_rdy", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("fl_sh_no_stale", seen, 0);
    send("fl_add", C_ADD, 32'd2, 32'd3, 5'd4, 1'b1);
    check("fl_add_res", bus.result, 32'd5);

    // Flush drops a held result and blocks a same-cycle accept.
    bus.out_ready = 1'b0;
    drive(C_ADD, 32'd9, 32'd9, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    check("fl_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_hold_vld", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_noacc_rdy", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_noacc_vld", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a shift restores every reset value.
    send("rs_sh", C_LSHIFT, 32'd1, 32'd20, 5'd5, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_vld",    {31'd0, bus.out_valid}, 32'd0);
    check("rs_result", bus.result, 32'd0);
    check("rs_zero",   {31'd0, bus.zero}, 32'd1);
    check("rs_rd",     {27'd0, bus.rd_out}, 32'd0);
    check("rs_wr",     {31'd0, bus.reg_wr_out}, 32'd0);
    #1;
    check("rs_rdy", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (25) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("rs_no_stale", seen, 0);
    send("rs_add", C_ADD, 32'd2, 32'd3, 5'd4, 1'b1);
    check("rs_add_res", bus.result, 32'd5);
    check("rs_add_rd",  {27'd0, bus.rd_out}, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
